// File: rtl/pll_lock_supervisor_if.sv
// Control/status bundle between the PLL lock supervisor and its surroundings.
// The supervisor side is the slave; the system/bench side is the master.
interface pll_lock_supervisor_if;
  logic       LOCK;
  logic       clear_fault;
  logic       pll_resetb;
  logic       sys_resetb;
  logic       locked;
  logic       fault;
  logic [7:0] lost_count;

  modport master (
    output LOCK, clear_fault,
    input  pll_resetb, sys_resetb, locked, fault, lost_count
  );

  modport slave (
    input  LOCK, clear_fault,
    output pll_resetb, sys_resetb, locked, fault, lost_count
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences PLL reset, waits for a stable lock, releases
// the downstream reset, and retries or faults on lock timeout / loss of lock.
module pll_lock_supervisor #(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 256,
  parameter int LOSS_FILTER   = 4,
  parameter int MAX_RETRIES   = 3
) (
  input logic                  REFERENCECLK,
  input logic                  RESETB,
  pll_lock_supervisor_if.slave bus
);

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b; else m = m;
    if (c > m) m = c; else m = m;
    if (d > m) m = d; else m = m;
    return m;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  localparam int CNT_W = $clog2(max_of4(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, LOSS_FILTER) + 1);
  localparam int RET_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOSS_LAST = CNT_W'(LOSS_FILTER - 1);
  localparam logic [RET_W-1:0] RET_MAX   = RET_W'(MAX_RETRIES);
  localparam logic [RET_W-1:0] RET_ONE   = RET_W'(1);

  typedef enum logic [2:0] {
    S_PLLRST   = 3'd0,
    S_WAITLOCK = 3'd1,
    S_SETTLE   = 3'd2,
    S_RUN      = 3'd3,
    S_FAULT    = 3'd4
  } state_t;

  state_t           state_r, state_n;
  logic [CNT_W-1:0] cnt_r, cnt_n;
  logic [RET_W-1:0] retries_r, retries_n;
  logic [7:0]       lost_r, lost_n;
  logic             sync1_r, lock_s;
  logic             pll_resetb_r, sys_resetb_r, locked_r, fault_r;

  // LOCK synchronizer; flushed while the PLL is held in reset so a stale lock is never trusted
  always_ff @(posedge REFERENCECLK or negedge RESETB) begin
    if (!RESETB) begin
      sync1_r <= 1'b0;
      lock_s  <= 1'b0;
    end else if (!pll_resetb_r) begin
      sync1_r <= 1'b0;
      lock_s  <= 1'b0;
    end else begin
      sync1_r <= bus.LOCK;
      lock_s  <= sync1_r;
    end
  end

  // State, shared counter, retry and loss-event registers
  always_ff @(posedge REFERENCECLK or negedge RESETB) begin
    if (!RESETB) begin
      state_r   <= S_PLLRST;
      cnt_r     <= '0;
      retries_r <= '0;
      lost_r    <= 8'd0;
    end else begin
      state_r   <= state_n;
      cnt_r     <= cnt_n;
      retries_r <= retries_n;
      lost_r    <= lost_n;
    end
  end

  // Next-state logic; the counter restarts on every state change
  always_comb begin
    state_n   = state_r;
    cnt_n     = cnt_r + CNT_ONE;
    retries_n = retries_r;
    lost_n    = lost_r;
    case (state_r)
      S_PLLRST: begin
        if (cnt_r == RST_LAST) state_n = S_WAITLOCK;
        else                   state_n = S_PLLRST;
      end
      S_WAITLOCK: begin
        if (lock_s) begin
          state_n = S_SETTLE;
        end else if (cnt_r == TMO_LAST) begin
          if (retries_r == RET_MAX) begin
            state_n = S_FAULT;
          end else begin
            retries_n = retries_r + RET_ONE;
            state_n   = S_PLLRST;
          end
        end else begin
          state_n = S_WAITLOCK;
        end
      end
      S_SETTLE: begin
        if (!lock_s) begin
          state_n = S_WAITLOCK;
        end else if (cnt_r == STB_LAST) begin
          state_n   = S_RUN;
          retries_n = '0;
        end else begin
          state_n = S_SETTLE;
        end
      end
      S_RUN: begin
        // counter here is the run length of consecutive lock_s lows
        if (lock_s) begin
          cnt_n = '0;
        end else if (cnt_r == LOSS_LAST) begin
          state_n = S_PLLRST;
          lost_n  = sat_inc8(lost_r);
        end else begin
          state_n = S_RUN;
        end
      end
      S_FAULT: begin
        cnt_n = '0;
        if (bus.clear_fault) begin
          state_n   = S_PLLRST;
          retries_n = '0;
        end else begin
          state_n = S_FAULT;
        end
      end
      default: begin
        state_n = S_PLLRST;
        cnt_n   = '0;
      end
    endcase
    if (state_n != state_r) cnt_n = '0;
    else                    cnt_n = cnt_n;
  end

  // Outputs decoded from the next state so they switch on the same edge as the state
  always_ff @(posedge REFERENCECLK or negedge RESETB) begin
    if (!RESETB) begin
      pll_resetb_r <= 1'b0;
      sys_resetb_r <= 1'b0;
      locked_r     <= 1'b0;
      fault_r      <= 1'b0;
    end else begin
      pll_resetb_r <= (state_n != S_PLLRST) && (state_n != S_FAULT);
      sys_resetb_r <= (state_n == S_RUN);
      locked_r     <= (state_n == S_RUN);
      fault_r      <= (state_n == S_FAULT);
    end
  end

  assign bus.pll_resetb = pll_resetb_r;
  assign bus.sys_resetb = sys_resetb_r;
  assign bus.locked     = locked_r;
  assign bus.fault      = fault_r;
  assign bus.lost_count = lost_r;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: a cycle-level reference model
// feeds an expected-output queue drained by a negedge monitor, plus timing checks.
module tb_pll_lock_supervisor;
  localparam int RC = 4;
  localparam int LT = 32;
  localparam int SC = 8;
  localparam int LF = 2;
  localparam int MR = 2;

  localparam int P_RST  = 0;
  localparam int P_WAIT = 1;
  localparam int P_SET  = 2;
  localparam int P_RUN  = 3;
  localparam int P_FLT  = 4;

  logic clk  = 1'b0;
  logic rstb = 1'b0;

  pll_lock_supervisor_if ifc();

  pll_lock_supervisor #(
    .RESET_CYCLES (RC),
    .LOCK_TIMEOUT (LT),
    .STABLE_CYCLES(SC),
    .LOSS_FILTER  (LF),
    .MAX_RETRIES  (MR)
  ) dut (
    .REFERENCECLK(clk),
    .RESETB      (rstb),
    .bus         (ifc)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  logic [11:0] exp_q[$];

  // reference model: phase, time spent in phase, retry/loss tallies, LOCK seen 1 and 2 edges ago
  int m_ph, m_el, m_tries, m_lost;
  bit m_q0, m_q1;
  logic p_lk, p_cf, p_rb;

  function automatic void model_reset();
    m_ph = P_RST; m_el = 0; m_tries = 0; m_lost = 0; m_q0 = 1'b0; m_q1 = 1'b0;
  endfunction

  function automatic void model_edge(input logic lk, input logic cf);
    bit ls;
    int np, ne;
    ls = m_q1;
    np = m_ph;
    ne = m_el + 1;
    if (m_ph == P_RST || m_ph == P_FLT) begin
      m_q0 = 1'b0; m_q1 = 1'b0;
    end else begin
      m_q1 = m_q0; m_q0 = lk;
    end
    case (m_ph)
      P_RST:  if (m_el == RC - 1) np = P_WAIT;
      P_WAIT: begin
        if (ls) np = P_SET;
        else if (m_el == LT - 1) begin
          if (m_tries == MR) np = P_FLT;
          else begin m_tries++; np = P_RST; end
        end
      end
      P_SET: begin
        if (!ls) np = P_WAIT;
        else if (m_el == SC - 1) begin np = P_RUN; m_tries = 0; end
      end
      P_RUN: begin
        if (ls) ne = 0;
        else if (m_el == LF - 1) begin
          np = P_RST;
          m_lost = (m_lost < 255) ? m_lost + 1 : 255;
        end
      end
      P_FLT: if (cf) begin np = P_RST; m_tries = 0; end
      default: np = P_RST;
    endcase
    m_el = (np != m_ph) ? 0 : ne;
    m_ph = np;
  endfunction

  function automatic logic [11:0] model_out();
    logic pll, run, flt;
    pll = (m_ph != P_RST) && (m_ph != P_FLT);
    run = (m_ph == P_RUN);
    flt = (m_ph == P_FLT);
    return {pll, run, run, flt, m_lost[7:0]};
  endfunction

  // one clock: advance the model over the edge, then apply the next inputs
  task automatic cyc(input logic lk, input logic cf, input logic rb);
    @(posedge clk);
    #1;
    if (p_rb) model_edge(p_lk, p_cf);
    if (!rb) model_reset();
    ifc.LOCK        = lk;
    ifc.clear_fault = cf;
    rstb            = rb;
    exp_q.push_back(model_out());
    p_lk = lk; p_cf = cf; p_rb = rb;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int outs();
    return int'({ifc.pll_resetb, ifc.sys_resetb, ifc.locked, ifc.fault, ifc.lost_count});
  endfunction

  // monitor: every cycle the DUT outputs are compared against the model's prediction
  always @(negedge clk) begin
    logic [11:0] e;
    logic [11:0] a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {ifc.pll_resetb, ifc.sys_resetb, ifc.locked, ifc.fault, ifc.lost_count};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL outputs @%0t: got pll=%b sys=%b locked=%b fault=%b lost=%0d, expected pll=%b sys=%b locked=%b fault=%b lost=%0d",
                 $time, a[11], a[10], a[9], a[8], a[7:0], e[11], e[10], e[9], e[8], e[7:0]);
      end
    end
  end

  initial begin
    int pr, sr, fr, rises;
    logic prev_pll, rl;
    int hold;

    ifc.LOCK = 1'b0; ifc.clear_fault = 1'b0; rstb = 1'b0;
    p_lk = 1'b0; p_cf = 1'b0; p_rb = 1'b0;
    model_reset();

    // LOCK tied high from reset
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    chk("reset_outputs", outs(), 0);
    cyc(1'b1, 1'b0, 1'b1);
    pr = -1; sr = -1;
    for (int k = 1; k <= 30; k++) begin
      cyc(1'b1, 1'b0, 1'b1);
      if (pr < 0 && ifc.pll_resetb === 1'b1) pr = k;
      if (sr < 0 && ifc.sys_resetb === 1'b1) sr = k;
    end
    chk("pll_resetb_rise_edge", pr, RC);
    chk("sys_resetb_rise_edge", sr, RC + 1 + SC + 2);
    chk("locked_in_run", int'(ifc.locked), 1);
    chk("lost_count_clean", int'(ifc.lost_count), 0);

    // single-cycle dropout is filtered; clear_fault in RUN is ignored
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    repeat (6) cyc(1'b1, 1'b0, 1'b1);
    chk("glitch_filtered", int'(ifc.sys_resetb), 1);

    // sustained dropout is a loss-of-lock event, followed by recovery
    repeat (3) cyc(1'b0, 1'b0, 1'b1);
    repeat (25) cyc(1'b1, 1'b0, 1'b1);
    chk("lost_count_after_loss", int'(ifc.lost_count), 1);
    chk("relocked_run", int'(ifc.sys_resetb), 1);

    // async reset in RUN
    cyc(1'b1, 1'b0, 1'b0);
    #1;
    chk("reset_in_run", outs(), 0);

    // LOCK tied low: retries exhaust into FAULT
    cyc(1'b0, 1'b0, 1'b1);
    fr = -1; rises = 0; prev_pll = 1'b0;
    for (int k = 1; k <= 120; k++) begin
      cyc(1'b0, 1'b0, 1'b1);
      if (fr < 0 && ifc.fault === 1'b1) fr = k;
      if (fr < 0 && ifc.pll_resetb === 1'b1 && prev_pll === 1'b0) rises++;
      prev_pll = ifc.pll_resetb;
    end
    chk("fault_rise_edge", fr, 3 * RC + 3 * LT);
    chk("pll_pulses_before_fault", rises, MR + 1);
    chk("pll_resetb_in_fault", int'(ifc.pll_resetb), 0);

    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("fault_cleared", int'(ifc.fault), 0);
    repeat (40) cyc(1'b0, 1'b0, 1'b1);
    chk("retries_restart", int'(ifc.fault), 0);
    repeat (80) cyc(1'b0, 1'b0, 1'b1);
    chk("fault_again", int'(ifc.fault), 1);

    // async reset in FAULT
    cyc(1'b0, 1'b0, 1'b0);
    #1;
    chk("reset_in_fault", outs(), 0);

    // lock_s arrives exactly on the last WAITLOCK cycle
    cyc(1'b0, 1'b0, 1'b1);
    sr = -1;
    for (int k = 1; k <= 60; k++) begin
      cyc(logic'(k >= RC + LT - 3), 1'b0, 1'b1);
      if (sr < 0 && ifc.sys_resetb === 1'b1) sr = k;
    end
    chk("timeout_edge_lock_wins", sr, RC + LT + SC);

    // LOCK dips while SETTLE counter is 5
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    sr = -1;
    for (int k = 1; k <= 40; k++) begin
      cyc(logic'(k != 10), 1'b0, 1'b1);
      if (sr < 0 && ifc.sys_resetb === 1'b1) sr = k;
    end
    chk("settle_drop_rerun_edge", sr, 12 + SC + 2);

    // randomized run-length LOCK, sporadic clear_fault and reset pulses
    rl = 1'b1; hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hold == 0) begin
        rl   = logic'($urandom_range(0, 99) < 65);
        hold = $urandom_range(1, 45);
      end
      hold--;
      cyc(rl, logic'($urandom_range(0, 29) == 0), logic'($urandom_range(0, 199) != 0));
    end

    repeat (3) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
